// File: rtl/rtc_prescaler.sv
// rtc_prescaler: programmable tick prescaler for the RTC counter stage.
// Divides clk_i by a handshaked divisor and emits one single-cycle tick_o per
// period. Optional build macro RTC_PRESCALER_CLAMP_EN: when defined, divisors
// 0 and 1 are clamped to 2; otherwise they are acknowledged and discarded.
module rtc_prescaler #(
    parameter int unsigned DIV_WIDTH = 20
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic                 div_valid_i,
    output logic                 div_ready_o,
    output logic                 div_done_o,
    output logic                 tick_o,
    output logic [DIV_WIDTH-1:0] div_cnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_e;

    localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] TWO = DIV_WIDTH'(2);

    state_e               state_q;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] cnt_q;
    logic                 tick_q;
    logic                 done_q;

    logic                 accept;
    logic                 div_ok;
    logic [DIV_WIDTH-1:0] div_eff;

    // Ready depends on state only: a divisor is taken in IDLE and RUN.
    assign div_ready_o = (state_q != LOAD);
    assign accept      = div_valid_i && div_ready_o;

    // Divisor legality: too-small divisors are either clamped or dropped.
    always_comb begin
        div_eff = div_i;
        div_ok  = 1'b1;
`ifdef RTC_PRESCALER_CLAMP_EN
        if (div_i < TWO) begin
            div_eff = TWO;
        end
`else
        if (div_i < TWO) begin
            div_ok = 1'b0;
        end
`endif
    end

    // Prescaler FSM with down-counter and registered tick/done.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (accept && div_ok) begin
            // New divisor aborts any running period without a tick.
            state_q <= LOAD;
            div_q   <= div_eff;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    state_q <= RUN;
                    cnt_q   <= div_q - ONE;
                    done_q  <= 1'b1;
                    tick_q  <= 1'b0;
                end
                RUN: begin
                    if (en_i && (cnt_q == '0)) begin
                        tick_q <= 1'b1;
                        cnt_q  <= div_q - ONE;
                    end else if (en_i) begin
                        tick_q <= 1'b0;
                        cnt_q  <= cnt_q - ONE;
                    end else begin
                        tick_q <= 1'b0;
                    end
                end
                default: begin
                    tick_q <= 1'b0;
                end
            endcase
        end
    end

    assign tick_o     = tick_q;
    assign div_done_o = done_q;
    assign div_cnt_o  = cnt_q;

endmodule

// File: tb/tb_rtc_prescaler.sv
// Self-checking bench for rtc_prescaler: directed scenarios plus random traffic
// checked every cycle against a period/elapsed-count reference model.
module tb_rtc_prescaler;

    localparam int unsigned DW = 20;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          en_i;
    logic [DW-1:0] div_i;
    logic          div_valid_i;
    logic          div_ready_o;
    logic          div_done_o;
    logic          tick_o;
    logic [DW-1:0] div_cnt_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: mode 0=idle 1=load 2=run; the count is derived from the
    // number of enabled run cycles elapsed since the divisor took effect.
    int              m_mode = 0;
    longint unsigned m_div  = 0;
    longint unsigned m_el   = 0;
    bit              m_tick = 0;
    bit              m_done = 0;

    rtc_prescaler #(.DIV_WIDTH(DW)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .en_i        (en_i),
        .div_i       (div_i),
        .div_valid_i (div_valid_i),
        .div_ready_o (div_ready_o),
        .div_done_o  (div_done_o),
        .tick_o      (tick_o),
        .div_cnt_o   (div_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    function automatic longint unsigned exp_cnt();
        if (m_mode == 2) return m_div - 1 - (m_el % m_div);
        return 0;
    endfunction

    // Advance model with the inputs presented to this edge, clock, then compare.
    task automatic step();
        bit              acc;
        bit              okd;
        longint unsigned d;
        acc = div_valid_i && (m_mode != 1);
        d   = longint'(div_i);
`ifdef RTC_PRESCALER_CLAMP_EN
        if (d < 2) d = 2;
        okd = 1'b1;
`else
        okd = (d >= 2);
`endif
        if (rst_i) begin
            m_mode = 0; m_div = 0; m_el = 0; m_tick = 0; m_done = 0;
        end else if (acc && okd) begin
            m_mode = 1; m_div = d; m_el = 0; m_tick = 0; m_done = 0;
        end else if (m_mode == 1) begin
            m_mode = 2; m_done = 1; m_el = 0; m_tick = 0;
        end else if (m_mode == 2 && en_i) begin
            m_tick = ((m_el % m_div) == m_div - 1);
            m_el++;
        end else begin
            m_tick = 0;
        end
        @(posedge clk_i);
        #1;
        cyc++;
        chk("tick",  32'(tick_o),      32'(m_tick));
        chk("done",  32'(div_done_o),  32'(m_done));
        chk("ready", 32'(div_ready_o), 32'(m_mode != 1));
        chk("cnt",   32'(div_cnt_o),   32'(exp_cnt()));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Present a divisor for exactly one edge.
    task automatic offer(input int d);
        div_i       = DW'(d);
        div_valid_i = 1'b1;
        step();
        div_valid_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
    endtask

    initial begin
        int acc_cyc;
        int t1;
        int t2;
        int ok;
        int nt;

        rst_i = 1'b1; en_i = 1'b0; div_i = '0; div_valid_i = 1'b0;
        step();
        chk("rst_ready", 32'(div_ready_o), 32'd1);
        chk("rst_cnt",   32'(div_cnt_o),   32'd0);
        rst_i = 1'b0;

        // div=4: first tick div+1 edges after the accept edge, then every 4.
        en_i = 1'b1;
        offer(4);
        acc_cyc = cyc;
        t1 = -1; t2 = -1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (tick_o && t1 < 0) t1 = cyc;
            else if (tick_o && t2 < 0) t2 = cyc;
        end
        chk("first_tick_dly", 32'(t1 - acc_cyc), 32'd5);
        chk("tick_period4",   32'(t2 - t1),      32'd4);

        // div=5: freeze for 7 cycles at count 2.
        offer(5);
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (m_mode == 2 && exp_cnt() == 2) ok = 1;
            else step();
        end
        chk("wait_cnt2", 32'(ok), 32'd1);
        en_i = 1'b0;
        run(7);
        chk("frozen_cnt", 32'(div_cnt_o), 32'd2);
        en_i = 1'b1;
        run(12);

        // div=8, then div=3 offered when the count is zero.
        offer(8);
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (m_mode == 2 && exp_cnt() == 0) ok = 1;
            else step();
        end
        chk("wait_cnt0", 32'(ok), 32'd1);
        offer(3);
        chk("abort_no_tick", 32'(tick_o), 32'd0);
        run(12);

        // Offer held across LOAD is taken in the first RUN cycle.
        offer(4);
        div_i = DW'(6); div_valid_i = 1'b1;
        step();
        step();
        div_valid_i = 1'b0;
        chk("held_offer_load", 32'(div_ready_o), 32'd0);
        run(16);
        chk("final_div6", 32'(m_div), 32'd6);

        // Divisor of 1 during a div=4 run.
        offer(4);
        run(6);
        offer(1);
        run(14);

        // Mid-period reset with div=10.
        offer(10);
        run(5);
        do_reset();
        chk("rst_mid_cnt", 32'(div_cnt_o), 32'd0);
        nt = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            nt += int'(tick_o);
        end
        chk("no_tick_after_rst", 32'(nt), 32'd0);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            en_i        = ($urandom_range(0, 4) != 0);
            rst_i       = ($urandom_range(0, 99) == 0);
            div_valid_i = ($urandom_range(0, 11) == 0);
            div_i       = ($urandom_range(0, 29) == 0) ? DW'($urandom) : DW'($urandom_range(0, 9));
            step();
        end
        rst_i = 1'b0; div_valid_i = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
